spi_mem_loader: RTL and testbench

SPI-mode-0 slave that deserialises a byte stream and writes it sequentially into the 164x8 parameter memory via its data_in/addr/write_enable port. Sits directly upstream of the memory; each chip-select frame reloads the memory from address 0. Reports completion and overflow to top-level status pins.

---
 rtl/spi_mem_loader_pkg.sv | 11 +
 rtl/spi_mem_loader_sync_2ff.sv | 21 ++
 rtl/spi_mem_loader.sv | 106 ++++++++++
 tb/tb_spi_mem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_loader_pkg.sv
// Shared sizing for the parameter memory and the loader's state encoding.
package spi_mem_loader_pkg;
  localparam int DEPTH  = 164;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;
endpackage

// File: rtl/spi_mem_loader_sync_2ff.sv
// Two-flop synchroniser with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that streams bytes into the parameter memory from address 0
// on every chip-select frame, flagging completion and overflow.
module spi_mem_loader
  import spi_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data,
  output logic              mem_we,
  output logic              load_done,
  output logic              overflow
);
  logic s_sclk, s_cs_n, s_mosi;
  logic sclk_d, cs_d;
  logic sclk_rise, cs_fall, cs_rise;
  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        bit_cnt;
  logic [WIDTH-1:0]  shift;
  logic [WIDTH-1:0]  byte_next;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(s_sclk));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n), .q(s_cs_n));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(s_mosi));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= s_sclk;
      cs_d   <= s_cs_n;
    end
  end

  assign sclk_rise = s_sclk & ~sclk_d;
  assign cs_fall   = ~s_cs_n & cs_d;
  assign cs_rise   = s_cs_n & ~cs_d;
  assign byte_next = {shift[WIDTH-2:0], s_mosi};

  // mem_we is registered on entry to WRITE so it is high exactly while in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state     <= SHIFT;
          ptr       <= '0;
          bit_cnt   <= '0;
          load_done <= 1'b0;
          overflow  <= 1'b0;
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state    <= WRITE;
              mem_we   <= 1'b1;
              mem_addr <= ptr;
              mem_data <= byte_next;
            end
          end
        end
        WRITE: begin
          ptr     <= ptr + 1'b1;
          bit_cnt <= '0;
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            load_done <= 1'b1;
            state     <= cs_rise ? IDLE : FULL;
          end else begin
            state <= cs_rise ? IDLE : SHIFT;
          end
        end
        default: begin
          // Memory is full: keep framing bytes so extra ones can be reported.
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) overflow <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_loader.sv
// Randomised SPI frames checked against a frame-level model of the memory image.
module tb_spi_mem_loader;
  import spi_mem_loader_pkg::*;

  localparam int HALF = 30;

  logic              clk = 1'b0;
  logic              reset, sclk, cs_n, mosi;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_data;
  logic              mem_we, load_done, overflow;

  int total = 0, bad = 0;
  logic [7:0] tx_q[$];
  int         wr_addr[$];
  logic [7:0] wr_data[$];
  int cyc = 0, last_we_cyc = -1, ld_rise_cyc = -1, consec = 0;
  logic we_prev = 1'b0, ld_prev = 1'b0;

  spi_mem_loader dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .load_done(load_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!reset && mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_data);
      last_we_cyc = cyc;
      if (we_prev) consec++;
    end
    if (load_done && !ld_prev) ld_rise_cyc = cyc;
    we_prev = mem_we;
    ld_prev = load_done;
  end

  // Frame-level model: what a frame of n whole bytes should leave behind.
  function automatic int exp_wr(input int n);
    return (n < DEPTH) ? n : DEPTH;
  endfunction
  function automatic logic exp_done(input int n);
    return n >= DEPTH;
  endfunction
  function automatic logic exp_ovf(input int n);
    return n > DEPTH;
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #(HALF); sclk = 1'b1;
      #(HALF); sclk = 1'b0;
    end
  endtask

  task automatic frame_open();
    wr_addr.delete(); wr_data.delete();
    ld_rise_cyc = -1; last_we_cyc = -1;
    cs_n = 1'b0;
    #(4*HALF);
  endtask

  task automatic frame_close();
    #(4*HALF); cs_n = 1'b1; #(4*HALF);
  endtask

  task automatic send_frame(input int n);
    frame_open();
    for (int i = 0; i < n; i++) spi_bits(tx_q[i], 8);
    frame_close();
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #22;
    total++;
    if ({mem_addr, mem_data, mem_we, load_done, overflow} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {mem_addr, mem_data, mem_we, load_done, overflow});
    end
    reset = 1'b0; #(4*HALF);
  endtask

  task automatic test_short_frame();
    tx_q = '{8'hA5, 8'h3C, 8'hFF};
    send_frame(3);
    total++;
    if (wr_addr.size() != 3) begin bad++; $display("FAIL short_count got=%0d want=3", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
        bad++; $display("FAIL short_write[%0d] got=%0d/%h want=%0d/%h", i, wr_addr[i], wr_data[i], i, tx_q[i]);
      end
    end
    total++;
    if ({load_done, overflow} !== 2'b00 || mem_addr !== 8'd2 || mem_data !== 8'hFF) begin
      bad++; $display("FAIL short_status got=%b%b %0d %h want=00 2 ff", load_done, overflow, mem_addr, mem_data);
    end
  endtask

  task automatic test_full_frame();
    tx_q.delete();
    for (int i = 0; i < DEPTH; i++) tx_q.push_back(8'(i));
    send_frame(DEPTH);
    total++;
    if (wr_addr.size() != exp_wr(DEPTH)) begin bad++; $display("FAIL full_count got=%0d want=%0d", wr_addr.size(), DEPTH); end
    for (int i = 0; i < wr_addr.size() && i < exp_wr(DEPTH); i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
        bad++; $display("FAIL full_write[%0d] got=%0d/%h want=%0d/%h", i, wr_addr[i], wr_data[i], i, tx_q[i]);
      end
    end
    total++;
    if (ld_rise_cyc - last_we_cyc != 1) begin
      bad++; $display("FAIL full_done_latency got=%0d want=1", ld_rise_cyc - last_we_cyc);
    end
    total++;
    if (load_done !== exp_done(DEPTH) || overflow !== exp_ovf(DEPTH)) begin
      bad++; $display("FAIL full_status got=%b%b want=%b%b", load_done, overflow, exp_done(DEPTH), exp_ovf(DEPTH));
    end
  endtask

  task automatic test_overflow();
    fill_random(DEPTH + 2);
    send_frame(DEPTH + 2);
    total++;
    if (wr_addr.size() != exp_wr(DEPTH + 2)) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", wr_addr.size(), DEPTH); end
    for (int i = 0; i < wr_addr.size() && i < exp_wr(DEPTH + 2); i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
        bad++; $display("FAIL ovf_write[%0d] got=%0d/%h want=%0d/%h", i, wr_addr[i], wr_data[i], i, tx_q[i]);
      end
    end
    total++;
    if (load_done !== exp_done(DEPTH + 2) || overflow !== exp_ovf(DEPTH + 2)) begin
      bad++; $display("FAIL ovf_status got=%b%b want=11", load_done, overflow);
    end
  endtask

  task automatic test_partial();
    frame_open();
    spi_bits(8'h81, 8);
    spi_bits(8'($urandom), 5);
    frame_close();
    total++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 0 || wr_data[0] !== 8'h81) begin
      bad++; $display("FAIL partial_write got_n=%0d want_n=1 addr0 data 81", wr_addr.size());
    end
    fill_random(1);
    send_frame(1);
    total++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 0 || wr_data[0] !== tx_q[0]) begin
      bad++; $display("FAIL partial_next got_n=%0d want_n=1 addr0 data %h", wr_addr.size(), tx_q[0]);
    end
    total++;
    if ({load_done, overflow} !== 2'b00) begin bad++; $display("FAIL partial_status got=%b%b want=00", load_done, overflow); end
  endtask

  task automatic test_mid_reset();
    fill_random(10);
    frame_open();
    for (int i = 0; i < 10; i++) spi_bits(tx_q[i], 8);
    #(4*HALF);
    reset = 1'b1; #3;
    total++;
    if ({mem_addr, mem_data, mem_we, load_done, overflow} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {mem_addr, mem_data, mem_we, load_done, overflow});
    end
    #(2*HALF); reset = 1'b0;
    wr_addr.delete(); wr_data.delete();
    #(4*HALF);
    fill_random(2);
    for (int i = 0; i < 2; i++) spi_bits(tx_q[i], 8);
    frame_close();
    total++;
    if (wr_addr.size() != 2) begin bad++; $display("FAIL midreset_count got=%0d want=2", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
        bad++; $display("FAIL midreset_write[%0d] got=%0d/%h want=%0d/%h", i, wr_addr[i], wr_data[i], i, tx_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      fill_random(DEPTH);
      frame_open();
      total++;
      if (load_done !== 1'b0) begin bad++; $display("FAIL b2b_clear[%0d] got=%b want=0", f, load_done); end
      for (int i = 0; i < DEPTH; i++) spi_bits(tx_q[i], 8);
      frame_close();
      total++;
      if (wr_addr.size() != DEPTH) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", f, wr_addr.size(), DEPTH); end
      for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
        total++;
        if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
          bad++; $display("FAIL b2b_write[%0d][%0d] got=%0d/%h want=%0d/%h", f, i, wr_addr[i], wr_data[i], i, tx_q[i]);
        end
      end
      total++;
      if (load_done !== 1'b1 || overflow !== 1'b0) begin
        bad++; $display("FAIL b2b_status[%0d] got=%b%b want=10", f, load_done, overflow);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int n;
      n = int'($urandom_range(1, 40));
      fill_random(n);
      send_frame(n);
      total++;
      if (wr_addr.size() != exp_wr(n)) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", f, wr_addr.size(), exp_wr(n)); end
      for (int i = 0; i < wr_addr.size() && i < exp_wr(n); i++) begin
        total++;
        if (wr_addr[i] !== i || wr_data[i] !== tx_q[i]) begin
          bad++; $display("FAIL rand_write[%0d][%0d] got=%0d/%h want=%0d/%h", f, i, wr_addr[i], wr_data[i], i, tx_q[i]);
        end
      end
      total++;
      if (load_done !== exp_done(n) || overflow !== exp_ovf(n)) begin
        bad++; $display("FAIL rand_status[%0d] got=%b%b want=%b%b", f, load_done, overflow, exp_done(n), exp_ovf(n));
      end
    end
    total++;
    if (consec != 0) begin bad++; $display("FAIL we_spacing got=%0d want=0", consec); end
  endtask

  initial begin
    #2;
    test_reset();
    test_short_frame();
    test_full_frame();
    test_overflow();
    test_partial();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
